fetch_pc_ras: RTL and testbench
===============================

# fetch_pc_ras

Parametrised fetch-stage program counter with an integrated return-address stack (RAS). Holds the architectural PC and drives the instruction memory address. Selects the next PC from sequential, register-jump, absolute-jump, sign-extended branch, call, return and flush sources. Calls push the link address; returns predict their target from the RAS and report mispredictions against the register value. Sits between the hazard/control unit and the icache interface, replacing the fixed 32-bit, stack-less PC.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits; must be 28..32 (elaboration assertion)
- PC_INIT, 0, reset PC; must be word-aligned
- RAS_DEPTH, 4, RAS entries; power of two, 2..16
- CNT_W, 16, width of the misprediction counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- pc_en  in  1  advance enable; 0 = stall, PC and RAS hold
- flush  in  1  redirect; overrides pc_en
- flush_addr  in  ADDR_W  redirect target
- pc_src  in  pcsrc_t (3)  next-PC select: SEQ, JR, JUMP, BRANCH, CALL, RET
- branch_taken  in  1  branch resolution, used only with BRANCH
- imm16  in  16  branch word offset, signed
- imm26  in  26  jump word index
- rdat1  in  ADDR_W  register operand (JR target, RET architectural target)
- imemaddr  out  ADDR_W  current PC
- pc_plus4  out  ADDR_W  PC+4, link value
- ras_empty, ras_full  out  1  RAS occupancy flags
- ras_miss  out  1  RET presented and predicted target ≠ rdat1 (combinational)
- miss_count  out  CNT_W  saturating count of ras_miss events

## Operation
- All arithmetic is modulo 2^ADDR_W. pc_plus4 = PC+4.
- SEQ: next = pc_plus4.
- JR: next = {rdat1[ADDR_W-1:2], 2'b00}.
- JUMP: next = {pc_plus4[ADDR_W-1:28], imm26, 2'b00}. At ADDR_W=28 there are no upper bits.
- BRANCH: next = branch_taken ? pc_plus4 + (sext(imm16) << 2) : pc_plus4. Negative offsets must work.
- CALL: next = JUMP target; push pc_plus4.
- RET: if RAS is non-empty, next = top and pop; if empty, next = aligned rdat1 and no pop. ras_miss = non-empty && top ≠ aligned rdat1. An empty-stack RET is never a miss.
- Undefined pc_src encodings: next = PC; no RAS change.
- RAS is circular. A push when full overwrites the oldest entry, count stays RAS_DEPTH, and ras_full stays 1. A pop when empty is a no-op.
- Priority: RST > flush > pc_en.
  - flush: PC ← {flush_addr[ADDR_W-1:2], 2'b00}; RAS contents and count retained; no push or pop; miss_count unchanged.
  - pc_en=0 and no flush: nothing changes, including miss_count. ras_miss may still assert combinationally.
- miss_count increments on a cycle with pc_en=1, flush=0, ras_miss=1, and saturates at all-ones.

## Timing
- Reset values: PC=PC_INIT, imemaddr=PC_INIT, pc_plus4=PC_INIT+4, RAS count 0, ras_empty=1, ras_full=0, ras_miss=0, miss_count=0.
- Latency: a next-PC selection appears on imemaddr one cycle after the enabling edge. imemaddr and pc_plus4 come straight from the PC register.
- RAS push and pop commit on the same edge as the PC update. A CALL immediately followed by RET returns the just-pushed link.
- RST asserted mid-stall or mid-flush forces the reset state on that edge; RAS entries become don't-care and the count is 0.
- No combinational path from pc_src or flush to imemaddr.

## Structure
- pcsrc_t enum (SEQ=0, JR=1, JUMP=2, BRANCH=3, CALL=4, RET=5) lives in cpu_types_pkg, alongside word_t.
- Sub-module ras_stack (params DEPTH, W):
  - inputs: push, pop, din
  - outputs: top, empty, full
  - holds the circular pointer and count
- The top level holds the PC register, next-PC mux, miss comparator and counter.

## Test plan
- Reset, then 3 SEQ cycles with pc_en=1 → imemaddr 0x0, 0x4, 0x8, 0xC. Stall 2 cycles → holds 0xC.
- PC=0x100, BRANCH, imm16=0xFFFE, taken → 0xFC. Same stimulus not taken → 0x104.
- PC=0x0, CALL imm26=0x40 → PC 0x100 and push 0x4. Then RET with rdat1=0x4 → PC 0x4, ras_miss=0, ras_empty=1.
- RAS_DEPTH=4: 5 CALLs (links L1..L5), then 5 RETs → targets L5, L4, L3, L2, then the 5th from rdat1. ras_full through the fifth push.
- RET with top=0x200 and rdat1=0x300 → PC 0x200, ras_miss=1, miss_count+1. Force miss_count to all-ones → stays saturated.
- flush with flush_addr=0x403 while pc_en=0 and pc_src=CALL → PC 0x400, RAS count unchanged. RST mid-sequence → PC_INIT, ras_empty=1, miss_count=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the next-PC source select.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    JR     = 3'd1,
    JUMP   = 3'd2,
    BRANCH = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } pcsrc_t;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, tptr;
  logic [CW-1:0] cnt;

  assign tptr  = wptr - PW'(1);
  assign top   = mem[tptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // Entries carry no reset; only pointer and count define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (push) begin
      wptr <= wptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      wptr <= tptr;
      cnt  <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_pc_ras.sv
// Fetch-stage PC with next-PC select and return-address prediction/miss tracking.
module fetch_pc_ras
  import cpu_types_pkg::*;
#(
  parameter int unsigned              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]        PC_INIT   = '0,
  parameter int unsigned              RAS_DEPTH = 4,
  parameter int unsigned              CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pc_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  pcsrc_t            pc_src,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rdat1,
  output logic [ADDR_W-1:0] imemaddr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_miss,
  output logic [CNT_W-1:0]  miss_count
);
  if (ADDR_W < 28 || ADDR_W > 32) begin : g_bad_addr_w
    $error("fetch_pc_ras: ADDR_W must be 28..32");
  end
  if (PC_INIT[1:0] != 2'b00) begin : g_bad_pc_init
    $error("fetch_pc_ras: PC_INIT must be word-aligned");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_pc_ras: RAS_DEPTH must be a power of two in 2..16");
  end

  logic [ADDR_W-1:0] pc, pc_nxt, jmp_tgt, br_off, rdat_al, ras_top;
  logic adv, push, pop, is_ret;
  logic unused_low_bits;

  assign unused_low_bits = ^{rdat1[1:0], flush_addr[1:0]};

  assign imemaddr = pc;
  assign pc_plus4 = pc + ADDR_W'(4);
  assign rdat_al  = {rdat1[ADDR_W-1:2], 2'b00};
  assign br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // At 28 bits the jump index covers the whole address space.
  if (ADDR_W > 28) begin : g_jmp_region
    assign jmp_tgt = {pc_plus4[ADDR_W-1:28], imm26, 2'b00};
  end else begin : g_jmp_flat
    assign jmp_tgt = {imm26, 2'b00};
  end

  assign adv      = pc_en & ~flush;
  assign is_ret   = (pc_src == RET);
  assign ras_miss = is_ret & ~ras_empty & (ras_top != rdat_al);
  assign push     = adv & (pc_src == CALL);
  assign pop      = adv & is_ret & ~ras_empty;

  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    pc_nxt = pc;
    case (pc_src)
      SEQ:    pc_nxt = pc_plus4;
      JR:     pc_nxt = rdat_al;
      JUMP:   pc_nxt = jmp_tgt;
      BRANCH: pc_nxt = branch_taken ? pc_plus4 + br_off : pc_plus4;
      CALL:   pc_nxt = jmp_tgt;
      RET:    pc_nxt = ras_empty ? rdat_al : ras_top;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)        pc <= PC_INIT;
    else if (flush) pc <= {flush_addr[ADDR_W-1:2], 2'b00};
    else if (pc_en) pc <= pc_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST)                                 miss_count <= '0;
    else if (adv && ras_miss && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_fetch_pc_ras.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_pc_ras;
  import cpu_types_pkg::*;
  localparam int AW = 32, DEPTH = 4, CW = 4;

  logic CLK = 1'b0;
  logic RST, pc_en, flush, branch_taken;
  logic [AW-1:0] flush_addr, rdat1;
  pcsrc_t pc_src;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [AW-1:0] imemaddr, pc_plus4;
  logic ras_empty, ras_full, ras_miss;
  logic [CW-1:0] miss_count;

  int n_vec = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_pc_ras #(.ADDR_W(AW), .PC_INIT(32'h0), .RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .flush(flush), .flush_addr(flush_addr),
    .pc_src(pc_src), .branch_taken(branch_taken), .imm16(imm16), .imm26(imm26),
    .rdat1(rdat1), .imemaddr(imemaddr), .pc_plus4(pc_plus4), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_miss(ras_miss), .miss_count(miss_count)
  );

  // Reference model: architectural PC, stack as a bounded queue, miss counter as an int.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int m_miss;

  function automatic logic m_ras_miss();
    return (pc_src == RET) && (m_ras.size() > 0) && (m_ras[$] != (rdat1 & 32'hFFFF_FFFC));
  endfunction

  task automatic tick();
    logic [31:0] p4, nxt;
    logic mm;
    p4 = m_pc + 32'd4;
    mm = m_ras_miss();
    nxt = m_pc;
    if (RST) begin
      m_pc = 32'h0; m_ras.delete(); m_miss = 0;
    end else if (flush) begin
      m_pc = flush_addr & 32'hFFFF_FFFC;
    end else if (pc_en) begin
      if (mm && m_miss < (1 << CW) - 1) m_miss++;
      case (pc_src)
        SEQ:    nxt = p4;
        JR:     nxt = rdat1 & 32'hFFFF_FFFC;
        JUMP:   nxt = (p4 & 32'hF000_0000) | (32'(imm26) << 2);
        BRANCH: nxt = branch_taken ? p4 + 32'(int'($signed(imm16)) * 4) : p4;
        CALL: begin
          nxt = (p4 & 32'hF000_0000) | (32'(imm26) << 2);
          m_ras.push_back(p4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        RET:    nxt = (m_ras.size() > 0) ? m_ras.pop_back() : (rdat1 & 32'hFFFF_FFFC);
        default: nxt = m_pc;
      endcase
      m_pc = nxt;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    RST = 0; flush = 0; pc_en = 1; pc_src = SEQ; branch_taken = 0;
    imm16 = '0; imm26 = '0; rdat1 = '0; flush_addr = '0;
  endtask

  task automatic do_reset();
    idle(); RST = 1; tick(); RST = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (imemaddr !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h exp 0", imemaddr); end
    n_vec++; if (pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc4 got %h exp 4", pc_plus4); end
    n_vec++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", ras_empty, ras_full); end
    n_vec++; if (ras_miss !== 1'b0 || miss_count !== '0) begin n_bad++; $display("FAIL reset_miss got m=%b c=%0d exp 0 0", ras_miss, miss_count); end
  endtask

  task automatic test_seq_stall();
    idle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (imemaddr !== 32'(i * 4)) begin n_bad++; $display("FAIL seq got %h exp %h", imemaddr, 32'(i * 4)); end
    end
    pc_en = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (imemaddr !== 32'hC) begin n_bad++; $display("FAIL stall got %h exp c", imemaddr); end
    end
  endtask

  task automatic test_branch();
    idle(); flush = 1; flush_addr = 32'h100; tick();
    flush = 0; pc_src = BRANCH; imm16 = 16'hFFFE; branch_taken = 1; tick();
    n_vec++; if (imemaddr !== 32'hFC) begin n_bad++; $display("FAIL branch_taken got %h exp fc", imemaddr); end
    flush = 1; tick();
    flush = 0; branch_taken = 0; tick();
    n_vec++; if (imemaddr !== 32'h104) begin n_bad++; $display("FAIL branch_not got %h exp 104", imemaddr); end
  endtask

  task automatic test_call_ret();
    do_reset();
    pc_src = CALL; imm26 = 26'h40; tick();
    n_vec++; if (imemaddr !== 32'h100 || ras_empty !== 1'b0) begin n_bad++; $display("FAIL call got pc=%h e=%b exp 100 0", imemaddr, ras_empty); end
    pc_src = RET; rdat1 = 32'h4; #1;
    n_vec++; if (ras_miss !== 1'b0) begin n_bad++; $display("FAIL call_ret_miss got %b exp 0", ras_miss); end
    tick();
    n_vec++; if (imemaddr !== 32'h4 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL ret got pc=%h e=%b exp 4 1", imemaddr, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] lnk [5];
    do_reset();
    pc_src = CALL;
    for (int i = 0; i < 5; i++) begin
      lnk[i] = m_pc + 32'd4;
      imm26 = 26'((i + 1) * 16);
      tick();
      n_vec++; if (ras_full !== (i >= 3)) begin n_bad++; $display("FAIL ovf_full push%0d got %b exp %b", i + 1, ras_full, i >= 3); end
    end
    pc_src = RET; rdat1 = 32'h1230;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (ras_miss !== (i < 4)) begin n_bad++; $display("FAIL ovf_miss ret%0d got %b exp %b", i + 1, ras_miss, i < 4); end
      tick();
      n_vec++; if (imemaddr !== ((i < 4) ? lnk[4 - i] : 32'h1230)) begin
        n_bad++; $display("FAIL ovf_ret%0d got %h exp %h", i + 1, imemaddr, (i < 4) ? lnk[4 - i] : 32'h1230);
      end
    end
  endtask

  task automatic test_miss_sat();
    do_reset();
    flush = 1; flush_addr = 32'h1FC; tick(); flush = 0;
    pc_src = CALL; imm26 = 26'h10; tick();
    pc_src = RET; rdat1 = 32'h300; #1;
    n_vec++; if (ras_miss !== 1'b1) begin n_bad++; $display("FAIL miss_comb got %b exp 1", ras_miss); end
    tick();
    n_vec++; if (imemaddr !== 32'h200 || miss_count !== 4'd1) begin n_bad++; $display("FAIL miss_ret got pc=%h c=%0d exp 200 1", imemaddr, miss_count); end
    pc_src = CALL; tick();
    pc_src = RET; pc_en = 0; #1;
    n_vec++; if (ras_miss !== 1'b1) begin n_bad++; $display("FAIL miss_stall_comb got %b exp 1", ras_miss); end
    tick();
    n_vec++; if (miss_count !== 4'd1 || imemaddr !== 32'h40) begin n_bad++; $display("FAIL miss_stall got c=%0d pc=%h exp 1 40", miss_count, imemaddr); end
    pc_en = 1;
    for (int i = 0; i < 20; i++) begin
      pc_src = RET; tick();
      pc_src = CALL; tick();
    end
    n_vec++; if (miss_count !== 4'hF) begin n_bad++; $display("FAIL miss_sat got %0d exp 15", miss_count); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    pc_src = CALL; imm26 = 26'h40; tick();
    pc_en = 0; flush = 1; flush_addr = 32'h403; tick();
    n_vec++; if (imemaddr !== 32'h400 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      n_bad++; $display("FAIL flush got pc=%h e=%b f=%b exp 400 0 0", imemaddr, ras_empty, ras_full);
    end
    flush = 0; pc_en = 1; pc_src = RET; rdat1 = 32'h4; tick();
    n_vec++; if (imemaddr !== 32'h4 || ras_empty !== 1'b1) begin n_bad++; $display("FAIL flush_ret got pc=%h e=%b exp 4 1", imemaddr, ras_empty); end
    pc_src = CALL; tick();
    pc_src = RET; rdat1 = 32'h300; tick();
    pc_src = CALL; tick();
    RST = 1; flush = 1; pc_en = 0; flush_addr = 32'h800; tick();
    RST = 0;
    n_vec++; if (imemaddr !== 32'h0 || ras_empty !== 1'b1 || miss_count !== '0) begin
      n_bad++; $display("FAIL rst_mid got pc=%h e=%b c=%0d exp 0 1 0", imemaddr, ras_empty, miss_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      RST = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 9) == 0);
      pc_en = ($urandom_range(0, 4) != 0);
      pc_src = pcsrc_t'(3'($urandom_range(0, 7)));
      branch_taken = 1'($urandom);
      imm16 = 16'($urandom);
      imm26 = 26'($urandom);
      flush_addr = $urandom;
      rdat1 = (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? (m_ras[$] | 32'($urandom_range(0, 3))) : $urandom;
      #1;
      n_vec++; if (ras_miss !== m_ras_miss()) begin n_bad++; $display("FAIL rnd_miss cyc%0d got %b exp %b", i, ras_miss, m_ras_miss()); end
      tick();
      n_vec++; if (imemaddr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        n_bad++; $display("FAIL rnd_pc cyc%0d got %h/%h exp %h", i, imemaddr, pc_plus4, m_pc);
      end
      n_vec++; if (ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin
        n_bad++; $display("FAIL rnd_flags cyc%0d got e=%b f=%b exp size %0d", i, ras_empty, ras_full, m_ras.size());
      end
      n_vec++; if (miss_count !== CW'(m_miss)) begin n_bad++; $display("FAIL rnd_cnt cyc%0d got %0d exp %0d", i, miss_count, m_miss); end
    end
  endtask

  initial begin
    m_pc = 0; m_miss = 0;
    idle(); RST = 1;
    test_reset();
    test_seq_stall();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_miss_sat();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
